// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - multi-cycle radix-2 restoring divide/remainder unit
//
// Executes div/divu/rem/remu and the word forms divw/divuw/remw/remuw.
// Optional build macro: DIV_EARLY_OUT_EN
//   (finishes in one cycle when |dividend| < |divisor|)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous abort back to IDLE, no result produced
//   in_valid_i   request valid
//   in_ready_o   unit can accept a request (IDLE only)
//   dividend_i   rs1 operand
//   divisor_i    rs2 operand
//   is_signed_i  1: signed operation, 0: unsigned
//   is_rem_i     1: return remainder, 0: return quotient
//   is_word_i    1: operate on the low WORD_W bits
//   out_valid_o  result valid (DONE)
//   out_ready_i  consumer accepts the result
//   result_o     registered quotient or remainder
//   busy_o       high in CALC or DONE
module div_iter_unit #(
  parameter int XLEN   = 64,
  parameter int WORD_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            is_signed_i,
  input  logic            is_rem_i,
  input  logic            is_word_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int              CNT_W    = $clog2(XLEN + 1);
  localparam int              WSHIFT   = XLEN - WORD_W;
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  // Low WORD_W bits set; also correct when WORD_W == XLEN.
  localparam logic [XLEN-1:0] WMASK    = ALL_ONES >> WSHIFT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic              is_word_q, is_word_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Word mode keeps the low WORD_W bits and extends them to XLEN.
  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] v,
                                             input logic            word,
                                             input logic            sgn);
    logic [XLEN-1:0] r;
    r = v;
    if (word) begin
      r = v & WMASK;
      if (sgn && v[WORD_W-1]) begin
        r = r | ~WMASK;
      end
    end
    return r;
  endfunction

  // Word results are always sign-extended, even for unsigned operations.
  function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v,
                                          input logic            word);
    return ext_op(v, word, 1'b1);
  endfunction

  // ---------------------------------------------------------------------
  // Operand preparation (used on the acceptance cycle)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] a_ext, b_ext;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] n_mask;
  logic [XLEN-1:0] min_neg;
  logic            div_zero;
  logic            ovf;
  logic            accept;

  always_comb begin
    a_ext    = ext_op(dividend_i, is_word_i, is_signed_i);
    b_ext    = ext_op(divisor_i, is_word_i, is_signed_i);
    // After extension the top bit carries the N-bit sign in both widths.
    a_neg    = is_signed_i & a_ext[XLEN-1];
    b_neg    = is_signed_i & b_ext[XLEN-1];
    a_mag    = a_neg ? (~a_ext + XLEN'(1)) : a_ext;
    b_mag    = b_neg ? (~b_ext + XLEN'(1)) : b_ext;
    n_mask   = is_word_i ? WMASK : ALL_ONES;
    // Most-negative N-bit value, sign-extended to XLEN.
    min_neg  = ~(n_mask >> 1);
    div_zero = (b_ext == '0);
    ovf      = is_signed_i && (a_ext == min_neg) && (b_ext == ALL_ONES);
    accept   = (state_q == S_IDLE) && in_valid_i && !flush_i;
  end

`ifdef DIV_EARLY_OUT_EN
  logic early;
  assign early = (a_mag < b_mag);
`endif

  // ---------------------------------------------------------------------
  // One restoring step: shift {rem, quo} left, trial-subtract divisor.
  // Bit XLEN of the difference is the borrow.
  // ---------------------------------------------------------------------
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic            no_borrow;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic [XLEN-1:0] q_fix, r_fix;

  always_comb begin
    trial     = {rem_q, quo_q[XLEN-1]};
    diff      = trial - {1'b0, dvsr_q};
    no_borrow = ~diff[XLEN];
    rem_nx    = no_borrow ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx    = {quo_q[XLEN-2:0], no_borrow};
    q_fix     = neg_quo_q ? (~quo_nx + XLEN'(1)) : quo_nx;
    r_fix     = neg_rem_q ? (~rem_nx + XLEN'(1)) : rem_nx;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    is_word_d = is_word_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_rem_d  = is_rem_i;
          is_word_d = is_word_i;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dvsr_d    = b_mag;
          rem_d     = '0;
          // Word dividends sit in the top of quo so that WORD_W shifts
          // bring every dividend bit through rem.
          quo_d     = is_word_i ? (a_mag << WSHIFT) : a_mag;
          cnt_d     = '0;
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = is_rem_i ? fmt(a_ext, is_word_i) : ALL_ONES;
          end else if (ovf) begin
            state_d  = S_DONE;
            result_d = is_rem_i ? '0 : fmt(a_ext, is_word_i);
          end
`ifdef DIV_EARLY_OUT_EN
          else if (early) begin
            state_d  = S_DONE;
            result_d = is_rem_i ? fmt(a_ext, is_word_i) : '0;
          end
`endif
          else begin
            state_d = S_CALC;
            cnt_d   = is_word_i ? CNT_W'(WORD_W) : CNT_W'(XLEN);
          end
        end
      end

      S_CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = fmt(is_rem_q ? r_fix : q_fix, is_word_q);
        end
      end

      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over acceptance and the output handshake.
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      is_word_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      is_word_q <= is_word_d;
      result_q  <= result_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - scoreboard bench for div_iter_unit
module tb_div_iter_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] dividend_i;
  logic [63:0] divisor_i;
  logic        is_signed_i;
  logic        is_rem_i;
  logic        is_word_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] result_o;
  logic        busy_o;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 65;
`endif

  div_iter_unit #(.XLEN(64), .WORD_W(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .is_signed_i (is_signed_i),
    .is_rem_i    (is_rem_i),
    .is_word_i   (is_word_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: records acceptance, checks latency of first out_valid and
  // the result on each output handshake against the scoreboard head.
  int acc_cyc = 0;
  bit waiting = 0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      waiting = 0;
    end else begin
      if (out_valid_o && waiting) begin
        waiting = 0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got result 0x%h, expected no output", result_o);
        end else begin
          check({sb[0].name, "_latency"}, 64'(cyc - acc_cyc), 64'(sb[0].lat));
        end
      end
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handshake: got result 0x%h, expected no output", result_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_result"}, result_o, e.res);
        end
      end
      if (in_valid_i && in_ready_o && !flush_i) begin
        acc_cyc = cyc;
        waiting = 1;
      end
    end
  end

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic r, input logic w);
    in_valid_i  = 1'b1;
    dividend_i  = a;
    divisor_i   = b;
    is_signed_i = s;
    is_rem_i    = r;
    is_word_i   = w;
  endtask

  task automatic issue(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic r, input logic w,
                       input logic [63:0] exp, input int lat, input bit push);
    int n;
    n = 0;
    @(posedge clk_i); #1;
    while (!in_ready_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!in_ready_o) begin
      checks++;
      errors++;
      $display("FAIL %s_in_ready_timeout: got in_ready 0, expected 1", name);
    end else begin
      drive(a, b, s, r, w);
      if (push) sb.push_back('{exp, lat, name});
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready_o) && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input string name, input logic [63:0] a, input logic [63:0] b,
                     input logic s, input logic r, input logic w,
                     input logic [63:0] exp, input int lat);
    issue(name, a, b, s, r, w, exp, lat, 1'b1);
    wait_drain(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    dividend_i  = '0;
    divisor_i   = '0;
    is_signed_i = 1'b0;
    is_rem_i    = 1'b0;
    is_word_i   = 1'b0;
    out_ready_i = 1'b1;

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_in_ready", 64'(in_ready_o), 64'd1);
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst_ni = 1'b1;

    // Directed vectors: name, dividend, divisor, signed, rem, word, expected, latency
    run("divu_100_7",   64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 65);
    run("remu_100_7",   64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2, 65);
    run("rem_m20_6",    64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("div_m20_6",    64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("divu_5_0",     64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remw_1234_0",  64'h1234, 64'd0, 1'b1, 1'b1, 1'b1, 64'h1234, 1);
    run("divw_ovf",     64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
    run("divuw_fff0_2", 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 1'b0, 1'b0, 1'b1, 64'h0000_0000_7FFF_FFF8, 33);
    run("divu_3_10",    64'd3, 64'd10, 1'b0, 1'b0, 1'b0, 64'd0, EO_LAT);
    run("remu_3_10",    64'd3, 64'd10, 1'b0, 1'b1, 1'b0, 64'd3, EO_LAT);
    run("rem_m3_10",    64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, EO_LAT);
    run("remw_m7_2",    64'hFFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("div_7_m2",     64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_min_m1",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'd0, 1);
    run("divuw_hi_3",   64'h1_0000_0010, 64'd3, 1'b0, 1'b0, 1'b1, 64'd5, 33);
    run("divw_100_m7",  64'd100, 64'hFFFF_FFF9, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 33);
    run("divuw_fffe_1", 64'hFFFF_FFFE, 64'd1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    // Backpressure: hold out_ready low for 10 cycles in DONE.
    out_ready_i = 1'b0;
    issue("bp_divu", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 65, 1'b1);
    n = 0;
    @(negedge clk_i);
    while (!out_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("bp_out_valid_seen", 64'(out_valid_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("bp_result_stable", result_o, 64'd14);
      check("bp_in_ready_low", 64'(in_ready_o), 64'd0);
    end
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_in_ready_at_handshake", 64'(in_ready_o), 64'd0);
    @(negedge clk_i);
    check("bp_in_ready_after", 64'(in_ready_o), 64'd1);
    wait_drain("bp_divu");

    // Flush in CALC cycle 20, new request accepted in the following cycle.
    issue("flushed", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd0, 0, 1'b0);
    repeat (19) begin
      @(posedge clk_i); #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    drive(64'd100, 64'd7, 1'b0, 1'b1, 1'b0);
    sb.push_back('{64'd2, 65, "post_flush"});
    @(negedge clk_i);
    check("flush_out_valid", 64'(out_valid_o), 64'd0);
    check("flush_in_ready", 64'(in_ready_o), 64'd1);
    check("flush_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("post_flush_accepted", 64'(busy_o), 64'd1);
    wait_drain("post_flush");

    // Flush while presenting a request in IDLE: not accepted.
    @(posedge clk_i); #1;
    drive(64'd9, 64'd3, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush_idle_not_accepted", 64'(busy_o), 64'd0);

    // Asynchronous reset in the middle of CALC.
    issue("reset_victim", 64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 64'd0, 0, 1'b0);
    repeat (10) begin
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b0;
    #1;
    check("midcalc_rst_in_ready", 64'(in_ready_o), 64'd1);
    check("midcalc_rst_out_valid", 64'(out_valid_o), 64'd0);
    check("midcalc_rst_busy", 64'(busy_o), 64'd0);
    check("midcalc_rst_result", result_o, 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    run("after_reset_divu", 64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 64'd333, 65);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
